// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset, IR/DR scans and idle clocks from a single command,
// generating TCK/TMS/TDI from the system clock and capturing TDO on each TCK rise.
module jtag_master #(
    parameter int HALF_PERIOD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO
);

    localparam logic [8:0] PH_RISE = 9'(HALF_PERIOD - 1);
    localparam logic [8:0] PH_FALL = 9'(2 * HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {T_RESET, T_IR, T_DR, T_IDLE} cmd_t;

    state_t      state_q, state_n;
    cmd_t        typ_q, typ_n;
    logic [5:0]  len_q, len_n;
    logic [31:0] data_q, data_n;
    logic [31:0] cap_q, cap_n;
    logic [31:0] rsp_data_q, rsp_data_n;
    logic        rsp_err_q, rsp_err_n;
    logic        ready_q, ready_n;
    logic        tck_q, tck_n;
    logic        tms_q, tms_n;
    logic        tdi_q, tdi_n;
    logic        first_q, first_n;
    logic [8:0]  ph_q, ph_n;
    logic [6:0]  bit_q, bit_n;
    logic [6:0]  len7, pre, nbits;
    logic        cmd_err;

    function automatic logic in_shift(input cmd_t t, input logic [6:0] p,
                                      input logic [6:0] l, input logic [6:0] b);
        return ((t == T_IR) || (t == T_DR)) && (b >= p) && (b < p + l);
    endfunction

    // Bit b of the whole sequence: preamble, shift bits (last one exits Shift), then Update -> Idle.
    function automatic logic tms_at(input cmd_t t, input logic [6:0] p,
                                    input logic [6:0] l, input logic [6:0] b);
        logic [6:0] post;
        post = p + l;
        case (t)
            T_RESET: return b < 7'd5;
            T_IR, T_DR: begin
                if (b < p)         return (b == 7'd0) || ((t == T_IR) && (b == 7'd1));
                else if (b < post) return b == post - 7'd1;
                else               return b == post;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic tdi_at(input cmd_t t, input logic [6:0] p, input logic [6:0] l,
                                    input logic [6:0] b, input logic [31:0] d);
        return in_shift(t, p, l, b) ? d[5'(b - p)] : 1'b0;
    endfunction

    always_comb begin
        len7 = {1'b0, len_q};
        case (typ_q)
            T_IR:    begin pre = 7'd4; nbits = len7 + 7'd6; end
            T_DR:    begin pre = 7'd3; nbits = len7 + 7'd5; end
            T_RESET: begin pre = 7'd0; nbits = 7'd6;        end
            default: begin pre = 7'd0; nbits = len7;        end
        endcase
        cmd_err = (typ_q != T_RESET) && ((len_q == 6'd0) || (len_q > 6'd32));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            typ_q      <= T_RESET;
            len_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            ready_q    <= 1'b0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            first_q    <= 1'b0;
            ph_q       <= '0;
            bit_q      <= '0;
        end else begin
            state_q    <= state_n;
            typ_q      <= typ_n;
            len_q      <= len_n;
            data_q     <= data_n;
            cap_q      <= cap_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            ready_q    <= ready_n;
            tck_q      <= tck_n;
            tms_q      <= tms_n;
            tdi_q      <= tdi_n;
            first_q    <= first_n;
            ph_q       <= ph_n;
            bit_q      <= bit_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        typ_n      = typ_q;
        len_n      = len_q;
        data_n     = data_q;
        cap_n      = cap_q;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        tck_n      = tck_q;
        tms_n      = tms_q;
        tdi_n      = tdi_q;
        first_n    = first_q;
        ph_n       = ph_q;
        bit_n      = bit_q;
        unique case (state_q)
            IDLE: begin
                tck_n = 1'b0;
                tdi_n = 1'b0;
                if (cmd_valid && ready_q) begin
                    state_n = RUN;
                    typ_n   = cmd_t'(cmd_type);
                    len_n   = cmd_len;
                    data_n  = cmd_data;
                    cap_n   = '0;
                    first_n = 1'b1;
                    ph_n    = '0;
                    bit_n   = '0;
                end
            end
            RUN: begin
                // The cycle after acceptance only decodes the command and presents bit 0.
                if (first_q) begin
                    first_n = 1'b0;
                    if (cmd_err) begin
                        state_n    = DONE;
                        rsp_err_n  = 1'b1;
                        rsp_data_n = '0;
                    end else begin
                        tms_n = tms_at(typ_q, pre, len7, 7'd0);
                        tdi_n = tdi_at(typ_q, pre, len7, 7'd0, data_q);
                        ph_n  = '0;
                    end
                end else begin
                    ph_n = ph_q + 9'd1;
                    if (ph_q == PH_RISE) begin
                        tck_n = 1'b1;
                        if (in_shift(typ_q, pre, len7, bit_q))
                            cap_n[5'(bit_q - pre)] = TDO;
                    end
                    if (ph_q == PH_FALL) begin
                        tck_n = 1'b0;
                        ph_n  = '0;
                        if (bit_q == nbits - 7'd1) begin
                            state_n    = DONE;
                            tdi_n      = 1'b0;
                            rsp_data_n = cap_q;
                            rsp_err_n  = 1'b0;
                        end else begin
                            bit_n = bit_q + 7'd1;
                            tms_n = tms_at(typ_q, pre, len7, bit_q + 7'd1);
                            tdi_n = tdi_at(typ_q, pre, len7, bit_q + 7'd1, data_q);
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign ready_n   = (state_n == IDLE);
    assign cmd_ready = ready_q;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: pin sequences, latency, capture, error and abort cases.
module tb_jtag_master;

    localparam int HP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        TCK, TMS, TDI, TDO;

    logic [1:0]  tdo_mode = 2'd0;
    logic        lb = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          tck_cnt = 0;
    int          rsp_cnt = 0;
    int          hi_run = 0;
    logic        p_tms = 1'b1;
    logic        p_tdi = 1'b0;
    logic        tms_log [0:4095];
    logic        tdi_log [0:4095];

    jtag_master #(.HALF_PERIOD(HP)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 clk = ~clk;

    // Target model: constant TDO, or TDI looped back through a TCK-rising flop.
    assign TDO = (tdo_mode == 2'd2) ? lb : tdo_mode[0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge TCK) begin
        if (tck_cnt < 4096) begin
            tms_log[tck_cnt] = TMS;
            tdi_log[tck_cnt] = TDI;
        end
        tck_cnt++;
        lb <= TDI;
    end

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (TMS !== p_tms || TDI !== p_tdi) check("pin_change_tck_low", 64'(TCK), 64'd0);
            if (TCK === 1'b1) hi_run++;
            else if (hi_run != 0) begin
                check("tck_high_len", 64'(hi_run), 64'(HP));
                hi_run = 0;
            end
        end else begin
            hi_run = 0;
        end
        p_tms = TMS;
        p_tdi = TDI;
    end

    function automatic logic [63:0] pack(input bit sel_tdi, input int b, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n && i < 64; i++) r[i] = sel_tdi ? tdi_log[b + i] : tms_log[b + i];
        return r;
    endfunction

    task automatic do_cmd(input string nm, input logic [1:0] t, input logic [5:0] l,
                          input logic [31:0] d, input bit hold, output int lat, output int base);
        int w;
        @(negedge clk);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check({nm, "_ready"}, 64'(cmd_ready), 64'd1);
        base = tck_cnt;
        cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        check({nm, "_busy_after_accept"}, 64'(busy), 64'd1);
        check({nm, "_ready_after_accept"}, 64'(cmd_ready), 64'd0);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 3000) begin @(negedge clk); lat++; end
        cmd_valid = 1'b0;
        check({nm, "_busy_in_rsp"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({nm, "_rsp_one_cycle"}, 64'(rsp_valid), 64'd0);
        check({nm, "_idle_busy"}, 64'(busy), 64'd0);
        check({nm, "_idle_ready"}, 64'(cmd_ready), 64'd1);
        check({nm, "_idle_tck"}, 64'(TCK), 64'd0);
        check({nm, "_idle_tdi"}, 64'(TDI), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, base, r0, w;
        rst = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_len = '0; cmd_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tck", 64'(TCK), 64'd0);
        check("rst_tms", 64'(TMS), 64'd1);
        check("rst_tdi", 64'(TDI), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(cmd_ready), 64'd1);

        // TAP reset, cmd_len ignored
        do_cmd("tap", 2'b00, 6'd40, 32'hDEAD_BEEF, 1'b0, lat, base);
        check("tap_lat", 64'(lat), 64'd25);
        check("tap_pulses", 64'(tck_cnt - base), 64'd6);
        check("tap_tms", pack(1'b0, base, 6), 64'h1F);
        check("tap_tdi", pack(1'b1, base, 6), 64'h0);
        check("tap_err", 64'(rsp_err), 64'd0);
        check("tap_data", 64'(rsp_data), 64'd0);
        check("tap_tms_idle", 64'(TMS), 64'd0);

        // DR scan with loopback target
        tdo_mode = 2'd2;
        do_cmd("dr8", 2'b10, 6'd8, 32'h0000_00A5, 1'b0, lat, base);
        check("dr8_lat", 64'(lat), 64'd53);
        check("dr8_pulses", 64'(tck_cnt - base), 64'd13);
        check("dr8_tms", pack(1'b0, base, 13), 64'hC01);
        check("dr8_tdi", pack(1'b1, base, 13), 64'h528);
        check("dr8_data", 64'(rsp_data), 64'h4A);
        check("dr8_err", 64'(rsp_err), 64'd0);

        // IR scan, TDO tied high: capture limited to len bits
        tdo_mode = 2'd1;
        do_cmd("ir4", 2'b01, 6'd4, 32'h0000_0002, 1'b0, lat, base);
        check("ir4_lat", 64'(lat), 64'd41);
        check("ir4_pulses", 64'(tck_cnt - base), 64'd10);
        check("ir4_tms", pack(1'b0, base, 10), 64'h183);
        check("ir4_tdi", pack(1'b1, base, 10), 64'h20);
        check("ir4_data", 64'(rsp_data), 64'hF);
        repeat (5) @(negedge clk);
        check("ir4_data_hold", 64'(rsp_data), 64'hF);

        do_cmd("dr32", 2'b10, 6'd32, 32'hFFFF_FFFF, 1'b0, lat, base);
        check("dr32_lat", 64'(lat), 64'd149);
        check("dr32_pulses", 64'(tck_cnt - base), 64'd37);
        check("dr32_tms", pack(1'b0, base, 37), 64'h0000_000C_0000_0001);
        check("dr32_tdi", pack(1'b1, base, 37), 64'h0000_0007_FFFF_FFF8);
        check("dr32_data", 64'(rsp_data), 64'hFFFF_FFFF);

        do_cmd("dr0", 2'b10, 6'd0, 32'h1234_5678, 1'b0, lat, base);
        check("dr0_lat", 64'(lat), 64'd1);
        check("dr0_pulses", 64'(tck_cnt - base), 64'd0);
        check("dr0_err", 64'(rsp_err), 64'd1);
        check("dr0_data", 64'(rsp_data), 64'd0);

        // Idle clocks; cmd_valid held high while busy must not start another command
        do_cmd("idle5", 2'b11, 6'd5, 32'hFFFF_FFFF, 1'b1, lat, base);
        check("idle5_lat", 64'(lat), 64'd21);
        check("idle5_pulses", 64'(tck_cnt - base), 64'd5);
        check("idle5_tms", pack(1'b0, base, 5), 64'h0);
        check("idle5_tdi", pack(1'b1, base, 5), 64'h0);
        check("idle5_data", 64'(rsp_data), 64'd0);
        check("idle5_err", 64'(rsp_err), 64'd0);

        do_cmd("dr33", 2'b10, 6'd33, 32'hFFFF_FFFF, 1'b0, lat, base);
        check("dr33_lat", 64'(lat), 64'd1);
        check("dr33_pulses", 64'(tck_cnt - base), 64'd0);
        check("dr33_err", 64'(rsp_err), 64'd1);
        check("dr33_data", 64'(rsp_data), 64'd0);

        // Abort a DR scan during its 5th TCK pulse
        @(negedge clk);
        base = tck_cnt; r0 = rsp_cnt;
        cmd_type = 2'b10; cmd_len = 6'd8; cmd_data = 32'h0F; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (tck_cnt - base < 5 && w < 500) begin @(negedge clk); w++; end
        check("abort_tck5_seen", 64'(tck_cnt - base), 64'd5);
        check("abort_tck_high", 64'(TCK), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("abort_tck", 64'(TCK), 64'd0);
        check("abort_tms", 64'(TMS), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_ready", 64'(cmd_ready), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_after_rst", 64'(cmd_ready), 64'd1);
        check("abort_busy_after_rst", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        check("abort_no_more_tck", 64'(tck_cnt - base), 64'd5);
        check("total_rsp_pulses", 64'(rsp_cnt), 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
